// File: rtl/updn_cnt_sched_pkg.sv
// Shared definitions for the up/down counter job scheduler.
//   state_t : scheduler FSM encoding (IDLE, CLR, RUN, DONE)
package updn_cnt_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/updn_cnt_sched_if.sv
// Bundle of requester-side and counter-side signals of the scheduler.
//   req/req_dir/req_len : per-requester job requests (client -> scheduler)
//   gnt/done/done_id/result : grant and completion info (scheduler -> client)
//   ctr_rst/ctr_en/ctr_up_dn : drive pins of the shared counter
//   ctr_count : counter value back to the scheduler
// slave modport is the scheduler view, master is the client/counter side.
interface updn_cnt_sched_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 4,
    parameter int LEN_W = 8
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       gnt;
    logic                  done;
    logic [ID_W-1:0]       done_id;
    logic [CNT_W-1:0]      result;
    logic                  ctr_rst;
    logic                  ctr_en;
    logic                  ctr_up_dn;
    logic [CNT_W-1:0]      ctr_count;

    modport slave (
        input  req, req_dir, req_len, ctr_count,
        output gnt, done, done_id, result, ctr_rst, ctr_en, ctr_up_dn
    );

    modport master (
        output req, req_dir, req_len, ctr_count,
        input  gnt, done, done_id, result, ctr_rst, ctr_en, ctr_up_dn
    );

endinterface

// File: rtl/updn_cnt_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i      : request vector
//   ptr_i      : highest-priority index this round
//   gnt_next_o : one-hot grant of the first set request at or after ptr_i
//   idx_o      : encoded index of gnt_next_o
module updn_cnt_sched_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]                                req_i,
    input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]     ptr_i,
    output logic [NREQ-1:0]                                gnt_next_o,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]     idx_o
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW   = ID_W + 1;

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_next_o = '0;
        idx_o      = '0;
        found      = 1'b0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One extra bit so the modulo wrap also works for non-power-of-two NREQ.
            cand = {1'b0, ptr_i} + IW'(k);
            if (cand >= IW'(NREQ)) begin
                cand = cand - IW'(NREQ);
            end
            if (!found && req_i[cand[ID_W-1:0]]) begin
                found                        = 1'b1;
                idx_o                        = cand[ID_W-1:0];
                gnt_next_o[cand[ID_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/updn_cnt_sched.sv
// Scheduler sharing one external up/down counter between NREQ requesters.
// Arbitrates round-robin, then clears the counter, enables it for len
// cycles in the latched direction and samples the final count.
//   clk, rst : clock, synchronous active-high reset
//   bus      : updn_cnt_sched_if.slave (requests, grant/done, counter pins)
//
// state | meaning
// IDLE  | arbitrate; latch id/dir/len of the winner
// CLR   | hold counter in reset, load remaining-cycle timer
// RUN   | counter enabled, timer counts down to terminal count 1
// DONE  | capture count into result, advance rr pointer
module updn_cnt_sched
    import updn_cnt_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 4,
    parameter int LEN_W = 8
) (
    input logic              clk,
    input logic              rst,
    updn_cnt_sched_if.slave  bus
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q;
    logic [ID_W-1:0]   id_q;
    logic              dir_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rem_q;
    logic [ID_W-1:0]   ptr_q;
    logic [CNT_W-1:0]  result_q;
    logic              done_q;
    logic [ID_W-1:0]   done_id_q;

    logic [NREQ-1:0]   arb_gnt;
    logic [ID_W-1:0]   arb_idx;
    logic              sel_dir;
    logic [LEN_W-1:0]  sel_len;

    logic [NREQ-1:0]   gnt_c;
    logic              ctr_rst_c;
    logic              ctr_en_c;
    logic              ctr_up_dn_c;

    updn_cnt_sched_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i      (bus.req),
        .ptr_i      (ptr_q),
        .gnt_next_o (arb_gnt),
        .idx_o      (arb_idx)
    );

    always_comb begin
        sel_dir = 1'b0;
        sel_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == ID_W'(i)) begin
                sel_dir = bus.req_dir[i];
                sel_len = bus.req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_c       = '0;
        ctr_rst_c   = rst;
        ctr_en_c    = 1'b0;
        ctr_up_dn_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) state_d = ST_CLR;
            end
            ST_CLR: begin
                gnt_c     = gnt_q;
                ctr_rst_c = 1'b1;
                state_d   = (len_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                gnt_c       = gnt_q;
                // Gated so the counter never sees rst and en together.
                ctr_en_c    = !rst;
                ctr_up_dn_c = dir_q & !rst;
                if (rem_q == LEN_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                gnt_c   = gnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            dir_q     <= 1'b0;
            len_q     <= '0;
            rem_q     <= '0;
            ptr_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_q <= arb_gnt;
                        id_q  <= arb_idx;
                        dir_q <= sel_dir;
                        len_q <= sel_len;
                    end
                end
                ST_CLR:  rem_q <= len_q;
                ST_RUN:  rem_q <= rem_q - LEN_W'(1);
                ST_DONE: begin
                    result_q  <= bus.ctr_count;
                    done_id_q <= id_q;
                    ptr_q     <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.ctr_rst   = ctr_rst_c;
    assign bus.ctr_en    = ctr_en_c;
    assign bus.ctr_up_dn = ctr_up_dn_c;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_updn_cnt_sched.sv
// Testbench for updn_cnt_sched with a behavioural up/down counter attached.
module tb_updn_cnt_sched;
    import updn_cnt_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int CNT_W = 4;
    localparam int LEN_W = 8;

    typedef struct {
        int         id;
        logic [3:0] res;
    } exp_t;

    typedef struct {
        int         id;
        bit         dir;
        int         len;
        bit         churn;
        logic [3:0] exp_res;
    } vec_t;

    logic clk;
    logic rst;
    logic [CNT_W-1:0] cnt_q;

    int   n_checks;
    int   n_err;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    updn_cnt_sched_if #(.NREQ(NREQ), .CNT_W(CNT_W), .LEN_W(LEN_W)) ifc ();

    updn_cnt_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached counter: synchronous clear, wraps modulo 2^CNT_W.
    always @(posedge clk) begin
        if (ifc.ctr_rst)     cnt_q <= '0;
        else if (ifc.ctr_en) cnt_q <= ifc.ctr_up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
    assign ifc.ctr_count = cnt_q;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Monitor: pops the scoreboard on every done pulse, checks invariants.
    always @(negedge clk) begin
        check("rst_en_excl", ifc.ctr_rst & ifc.ctr_en, 0);
        if (!rst) begin
            check("gnt_onehot", ($countones(ifc.gnt) <= 1), 1);
            if (ifc.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_id", ifc.done_id, mon_e.id);
                    check("result", ifc.result, mon_e.res);
                end
            end
        end
    end

    task automatic run_job(input int id, input bit dir, input int len, input bit churn,
                           input logic [3:0] exp_res);
        int   gc, ec, udm, done_at;
        bit   seen;
        exp_t e;
        @(negedge clk);
        ifc.req_dir[id] = dir;
        ifc.req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
        ifc.req[id] = 1'b1;
        e.id = id; e.res = exp_res;
        sb.push_back(e);
        gc = 0; ec = 0; udm = 0; seen = 0; done_at = 0;
        for (int c = 1; c <= 600 && !seen; c++) begin
            @(negedge clk);
            if (ifc.gnt[id]) begin
                gc++;
                ifc.req[id] = 1'b0;
            end
            if (ifc.ctr_en) begin
                ec++;
                if (ifc.ctr_up_dn !== dir) udm++;
            end
            if (churn && gc == 3) begin
                ifc.req_dir[id] = ~dir;
                ifc.req_len[id*LEN_W +: LEN_W] = LEN_W'(len + 7);
                ifc.req[id] = 1'b0;
            end
            if (ifc.done) begin
                seen = 1'b1;
                done_at = c;
            end
        end
        check("done_seen", seen, 1);
        check("latency", done_at, len + 3);
        check("gnt_cycles", gc, len + 2);
        check("en_cycles", ec, len);
        check("up_dn_dir", udm, 0);
        @(negedge clk);
        check("done_one_cycle", ifc.done, 0);
        check("result_hold", ifc.result, exp_res);
    endtask

    initial begin
        int   ng, ndone, ec, prev;
        int   rr_order[5];
        exp_t e;

        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        ifc.req     = '0;
        ifc.req_dir = '0;
        ifc.req_len = '0;

        vecs[0] = '{id: 0, dir: 1'b1, len: 5,  churn: 1'b0, exp_res: 4'd5};
        vecs[1] = '{id: 2, dir: 1'b0, len: 3,  churn: 1'b0, exp_res: 4'd13};
        vecs[2] = '{id: 1, dir: 1'b1, len: 0,  churn: 1'b0, exp_res: 4'd0};
        vecs[3] = '{id: 3, dir: 1'b1, len: 20, churn: 1'b0, exp_res: 4'd4};
        vecs[4] = '{id: 1, dir: 1'b0, len: 0,  churn: 1'b0, exp_res: 4'd0};
        vecs[5] = '{id: 0, dir: 1'b0, len: 17, churn: 1'b0, exp_res: 4'd15};
        vecs[6] = '{id: 1, dir: 1'b1, len: 4,  churn: 1'b1, exp_res: 4'd4};
        vecs[7] = '{id: 3, dir: 1'b0, len: 16, churn: 1'b0, exp_res: 4'd0};

        repeat (3) @(negedge clk);
        check("rst_gnt", ifc.gnt, 0);
        check("rst_done", ifc.done, 0);
        check("rst_done_id", ifc.done_id, 0);
        check("rst_result", ifc.result, 0);
        check("rst_ctr_en", ifc.ctr_en, 0);
        check("rst_ctr_up_dn", ifc.ctr_up_dn, 0);
        check("rst_ctr_rst", ifc.ctr_rst, 1);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_job(vecs[v].id, vecs[v].dir, vecs[v].len, vecs[v].churn, vecs[v].exp_res);
        end

        // Round-robin with all requests held; pointer starts at 0 after reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ifc.req_dir[i] = 1'b1;
            ifc.req_len[i*LEN_W +: LEN_W] = LEN_W'(i + 1);
        end
        rr_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            e.id = rr_order[k];
            e.res = 4'(rr_order[k] + 1);
            sb.push_back(e);
        end
        ifc.req = 4'b1111;
        ng = 0; ndone = 0; prev = 0;
        for (int c = 0; c < 400 && ndone < 5; c++) begin
            @(negedge clk);
            if (ifc.gnt != 0 && prev == 0) begin
                if (ng < 5) check("rr_order", oh_idx(ifc.gnt), rr_order[ng]);
                ng++;
                if (ng == 5) ifc.req = '0;
            end
            prev = int'(ifc.gnt);
            if (ifc.done) ndone++;
        end
        check("rr_grants", ng, 5);
        check("rr_dones", ndone, 5);

        // Reset in the second RUN cycle of a len=6 job.
        @(negedge clk);
        ifc.req_dir[0] = 1'b1;
        ifc.req_len[0*LEN_W +: LEN_W] = 8'd6;
        ifc.req[0] = 1'b1;
        ec = 0;
        for (int c = 0; c < 50 && ec < 2; c++) begin
            @(negedge clk);
            if (ifc.gnt[0]) ifc.req[0] = 1'b0;
            if (ifc.ctr_en) ec++;
        end
        check("rstrun_reached", ec, 2);
        rst = 1'b1;
        ifc.req = '0;
        @(negedge clk);
        check("rstrun_gnt", ifc.gnt, 0);
        check("rstrun_ctr_en", ifc.ctr_en, 0);
        check("rstrun_ctr_rst", ifc.ctr_rst, 1);
        check("rstrun_done", ifc.done, 0);
        check("rstrun_result", ifc.result, 0);
        @(negedge clk);
        check("rstrun_ctr_rst2", ifc.ctr_rst, 1);
        check("rstrun_done2", ifc.done, 0);

        ifc.req_dir[0] = 1'b1;
        ifc.req_len[0*LEN_W +: LEN_W] = 8'd2;
        ifc.req_dir[1] = 1'b0;
        ifc.req_len[1*LEN_W +: LEN_W] = 8'd3;
        e.id = 0; e.res = 4'd2;  sb.push_back(e);
        e.id = 1; e.res = 4'd13; sb.push_back(e);
        ifc.req = 4'b0011;
        rst = 1'b0;
        ng = 0; ndone = 0; prev = 0;
        for (int c = 0; c < 200 && ndone < 2; c++) begin
            @(negedge clk);
            if (ifc.gnt != 0 && prev == 0) begin
                if (ng == 0) check("post_rst_first", oh_idx(ifc.gnt), 0);
                if (ng == 1) check("post_rst_second", oh_idx(ifc.gnt), 1);
                ng++;
            end
            if (ifc.gnt[0]) ifc.req[0] = 1'b0;
            if (ifc.gnt[1]) ifc.req[1] = 1'b0;
            prev = int'(ifc.gnt);
            if (ifc.done) ndone++;
        end
        check("post_rst_dones", ndone, 2);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
